// File: rtl/cpu_br_pkg.sv
// Branch opcode definitions and outcome helpers, shared between the
// branch predictor and the decoder.
package cpu_br_pkg;

    localparam logic [4:0] BEQ = 5'b10011;
    localparam logic [4:0] BLT = 5'b10100;
    localparam logic [4:0] BGT = 5'b10101;
    localparam logic [4:0] BNE = 5'b10110;

    typedef logic [1:0] bht_ctr_t;

    function automatic logic is_branch(input logic [4:0] opcode);
        return (opcode == BEQ) || (opcode == BLT) || (opcode == BGT) || (opcode == BNE);
    endfunction

    // flags[1] = Z (equal), flags[0] = N (less-than)
    function automatic logic br_actual(input logic [4:0] opcode, input logic [1:0] flags);
        logic z;
        logic n;
        z = flags[1];
        n = flags[0];
        case (opcode)
            BEQ:     return z;
            BNE:     return !z;
            BLT:     return n;
            BGT:     return !z && !n;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/br_pred_fifo.sv
// In-flight prediction FIFO. Pointers carry one extra bit so full and
// empty are distinguishable; clr empties the FIFO and overrides push.
module br_pred_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is only accepted when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // next pointers and storage contents
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // pointer and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: 2-bit counter BHT read at fetch, FIFO of in-flight
// predictions resolved at EX, flush/redirect and saturating statistics.
module branch_predict_unit
    import cpu_br_pkg::*;
#(
    parameter int       PC_W     = 16,
    parameter int       IDX_W    = 4,
    parameter bht_ctr_t INIT_CTR = 2'b01,
    parameter int       QDEPTH   = 4,
    parameter int       CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fet_vld,
    input  logic [PC_W-1:0]  fet_pc,
    input  logic [4:0]       fet_opcode,
    output logic             pred_taken,
    output logic             q_full,
    input  logic             ex_vld,
    input  logic [4:0]       ex_opcode,
    input  logic [1:0]       ex_flags,
    output logic             pc_branch_sel_out,
    output logic             flush,
    output logic             q_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int NENT = 1 << IDX_W;

    bht_ctr_t         bht_q [NENT];
    bht_ctr_t         bht_d [NENT];
    logic             q_err_q, q_err_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             ex_br;
    logic             actual;
    logic             q_empty;
    logic             head_pred;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W:0]   fifo_dout;
    logic             push;
    logic             unused_pc_hi;

    assign unused_pc_hi = ^fet_pc;

    assign pred_taken = bht_q[fet_pc[IDX_W-1:0]][1];
    assign ex_br      = ex_vld && is_branch(ex_opcode);
    assign actual     = br_actual(ex_opcode, ex_flags);
    assign head_idx   = fifo_dout[IDX_W:1];
    // an empty FIFO at resolve is treated as a not-taken prediction
    assign head_pred  = q_empty ? 1'b0 : fifo_dout[0];

    assign pc_branch_sel_out = ex_br && actual;
    assign flush             = ex_br && (actual != head_pred);
    assign push              = fet_vld && is_branch(fet_opcode) && (!q_full || ex_br) && !flush;

    br_pred_fifo #(
        .WIDTH (IDX_W + 1),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (ex_br),
        .clr   (flush),
        .din   ({fet_pc[IDX_W-1:0], pred_taken}),
        .dout  (fifo_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    // counter training on resolve, error flag and saturating statistics
    always_comb begin
        bht_d         = bht_q;
        q_err_d       = q_err_q;
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_br) begin
            if (q_empty) begin
                q_err_d = 1'b1;
            end else if (actual) begin
                if (bht_q[head_idx] != 2'b11) bht_d[head_idx] = bht_q[head_idx] + 2'b01;
            end else begin
                if (bht_q[head_idx] != 2'b00) bht_d[head_idx] = bht_q[head_idx] - 2'b01;
            end
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
            if (flush && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    // BHT and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) begin
                bht_q[i] <= INIT_CTR;
            end
            q_err_q       <= 1'b0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            bht_q         <= bht_d;
            q_err_q       <= q_err_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign q_err       = q_err_q;
    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios plus a randomized run,
// all compared against a queue/array reference model of the predictor.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic        fet_vld;
    logic [15:0] fet_pc;
    logic [4:0]  fet_opcode;
    logic        ex_vld;
    logic [4:0]  ex_opcode;
    logic [1:0]  ex_flags;

    logic        pred_taken, q_full, pc_branch_sel_out, flush, q_err;
    logic [15:0] br_cnt, mispred_cnt;
    logic        pred_taken4, q_full4, sel4, flush4, q_err4;
    logic [3:0]  br_cnt4, mispred_cnt4;

    int n_checks = 0;
    int n_errors = 0;

    branch_predict_unit dut (
        .clk (clk), .rst_n (rst_n),
        .fet_vld (fet_vld), .fet_pc (fet_pc), .fet_opcode (fet_opcode),
        .pred_taken (pred_taken), .q_full (q_full),
        .ex_vld (ex_vld), .ex_opcode (ex_opcode), .ex_flags (ex_flags),
        .pc_branch_sel_out (pc_branch_sel_out), .flush (flush), .q_err (q_err),
        .br_cnt (br_cnt), .mispred_cnt (mispred_cnt)
    );

    branch_predict_unit #(.CNT_W (4)) dut4 (
        .clk (clk), .rst_n (rst_n),
        .fet_vld (fet_vld), .fet_pc (fet_pc), .fet_opcode (fet_opcode),
        .pred_taken (pred_taken4), .q_full (q_full4),
        .ex_vld (ex_vld), .ex_opcode (ex_opcode), .ex_flags (ex_flags),
        .pc_branch_sel_out (sel4), .flush (flush4), .q_err (q_err4),
        .br_cnt (br_cnt4), .mispred_cnt (mispred_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    typedef struct { int idx; bit pred; } ent_t;
    int   bht_m [16];
    ent_t q_m [$];
    int   br_m, mis_m, br4_m, mis4_m;
    bit   qerr_m;
    bit   e_pred, e_full, e_exbr, e_act, e_flush, e_sel, e_push;

    function automatic bit m_isbr(logic [4:0] op);
        return (op == 5'h13) || (op == 5'h14) || (op == 5'h15) || (op == 5'h16);
    endfunction

    function automatic bit m_taken(logic [4:0] op, logic [1:0] fl);
        bit z = fl[1];
        bit n = fl[0];
        if (op == 5'h13) return z;
        if (op == 5'h16) return !z;
        if (op == 5'h14) return n;
        if (op == 5'h15) return !z && !n;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 1;
        q_m.delete();
        br_m = 0; mis_m = 0; br4_m = 0; mis4_m = 0; qerr_m = 0;
    endtask

    task automatic model_eval();
        bit hp;
        e_pred  = bht_m[fet_pc[3:0]] >= 2;
        e_full  = q_m.size() == 4;
        e_exbr  = ex_vld && m_isbr(ex_opcode);
        e_act   = m_taken(ex_opcode, ex_flags);
        hp      = (q_m.size() > 0) ? q_m[0].pred : 1'b0;
        e_sel   = e_exbr && e_act;
        e_flush = e_exbr && (e_act != hp);
        e_push  = fet_vld && m_isbr(fet_opcode) && (!e_full || e_exbr) && !e_flush;
    endtask

    task automatic model_commit();
        ent_t e;
        if (e_exbr) begin
            if (q_m.size() > 0) begin
                e = q_m.pop_front();
                if (e_act) bht_m[e.idx] = (bht_m[e.idx] == 3) ? 3 : bht_m[e.idx] + 1;
                else       bht_m[e.idx] = (bht_m[e.idx] == 0) ? 0 : bht_m[e.idx] - 1;
            end else begin
                qerr_m = 1;
            end
            if (br_m < 65535) br_m++;
            if (br4_m < 15) br4_m++;
            if (e_flush && mis_m < 65535) mis_m++;
            if (e_flush && mis4_m < 15) mis4_m++;
            if (e_flush) q_m.delete();
        end
        if (e_push) q_m.push_back('{int'(fet_pc[3:0]), e_pred});
    endtask

    // drive one cycle's inputs and move to the sampling point (negedge)
    task automatic step(input bit fv, input logic [15:0] pc, input logic [4:0] fop,
                        input bit ev, input logic [4:0] eop, input logic [1:0] fl);
        fet_vld = fv; fet_pc = pc; fet_opcode = fop;
        ex_vld = ev; ex_opcode = eop; ex_flags = fl;
        @(negedge clk);
        model_eval();
    endtask

    task automatic commit();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 16'h0, 5'h0, 0, 5'h0, 2'b00);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q_err !== 1'b0) begin n_errors++; $display("FAIL reset_q_err: got %b want 0", q_err); end
        n_checks++;
        if (br_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_br_cnt: got %0d want 0", br_cnt); end
        n_checks++;
        if (mispred_cnt !== 16'd0 || q_full !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_misc: mispred=%0d q_full=%b flush=%b want 0 0 0", mispred_cnt, q_full, flush);
        end
        for (int i = 0; i < 16; i++) begin
            fet_pc = 16'(i);
            #1;
            n_checks++;
            if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_pred idx%0d: got %b want 0", i, pred_taken); end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mispredict();
        step(1, 16'h0005, 5'h13, 0, 5'h0, 2'b00);
        n_checks++;
        if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL mp_pred0: got %b want 0", pred_taken); end
        commit();
        step(0, 16'h0, 5'h0, 1, 5'h13, 2'b10);
        n_checks++;
        if (pc_branch_sel_out !== 1'b1 || flush !== 1'b1) begin
            n_errors++; $display("FAIL mp_resolve: sel=%b flush=%b want 1 1", pc_branch_sel_out, flush);
        end
        commit();
        step(0, 16'h0015, 5'h0, 0, 5'h0, 2'b00);
        n_checks++;
        if (pred_taken !== 1'b1 || bht_m[5] != 2) begin n_errors++; $display("FAIL mp_bht5: pred=%b want 1", pred_taken); end
        n_checks++;
        if (br_cnt !== 16'd1 || mispred_cnt !== 16'd1) begin
            n_errors++; $display("FAIL mp_cnts: br=%0d mis=%0d want 1 1", br_cnt, mispred_cnt);
        end
        commit();
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            step(1, 16'h0020 + 16'(i), 5'h16, 0, 5'h0, 2'b00);
            if (i == 4) begin
                n_checks++;
                if (q_full !== 1'b1) begin n_errors++; $display("FAIL full_after4: got %b want 1", q_full); end
            end
            commit();
        end
        step(0, 16'h0, 5'h0, 1, 5'h16, 2'b00);
        n_checks++;
        if (flush !== 1'b1 || pc_branch_sel_out !== 1'b1) begin
            n_errors++; $display("FAIL full_flush: flush=%b sel=%b want 1 1", flush, pc_branch_sel_out);
        end
        commit();
        step(0, 16'h0, 5'h0, 0, 5'h0, 2'b00);
        n_checks++;
        if (q_full !== 1'b0 || q_m.size() != 0) begin n_errors++; $display("FAIL full_cleared: q_full=%b want 0", q_full); end
        commit();
    endtask

    task automatic test_saturate();
        int mis0;
        mis0 = mis_m;
        for (int i = 0; i < 4; i++) begin
            step(1, 16'h0007, 5'h14, 0, 5'h0, 2'b00);
            commit();
            step(0, 16'h0, 5'h0, 1, 5'h14, 2'b01);
            n_checks++;
            if (flush !== (i == 0)) begin n_errors++; $display("FAIL sat_flush it%0d: got %b want %b", i, flush, i == 0); end
            commit();
        end
        step(0, 16'h0, 5'h0, 0, 5'h0, 2'b00);
        n_checks++;
        if (mispred_cnt !== 16'(mis0 + 1)) begin n_errors++; $display("FAIL sat_mis: got %0d want %0d", mispred_cnt, mis0 + 1); end
        commit();
        // one not-taken from a saturated 3 leaves the counter at 2 (still taken)
        step(1, 16'h0007, 5'h14, 0, 5'h0, 2'b00);
        commit();
        step(0, 16'h0, 5'h0, 1, 5'h14, 2'b00);
        commit();
        step(0, 16'h0007, 5'h0, 0, 5'h0, 2'b00);
        n_checks++;
        if (pred_taken !== 1'b1 || bht_m[7] != 2) begin n_errors++; $display("FAIL sat_hold: pred=%b want 1", pred_taken); end
        commit();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pcs [5];
        pcs[0] = 16'h0005; pcs[1] = 16'h0008; pcs[2] = 16'h0007; pcs[3] = 16'h0009; pcs[4] = 16'h000A;
        for (int i = 0; i < 4; i++) begin
            step(1, pcs[i], 5'h13, 0, 5'h0, 2'b00);
            commit();
        end
        // push the fifth while the head (pred=1) resolves correctly
        step(1, pcs[4], 5'h13, 1, 5'h13, 2'b10);
        n_checks++;
        if (flush !== 1'b0 || q_full !== 1'b1) begin
            n_errors++; $display("FAIL b2b_same: flush=%b q_full=%b want 0 1", flush, q_full);
        end
        commit();
        step(0, 16'h0, 5'h0, 0, 5'h0, 2'b00);
        n_checks++;
        if (q_full !== 1'b1) begin n_errors++; $display("FAIL b2b_stillfull: got %b want 1", q_full); end
        commit();
        for (int i = 1; i < 5; i++) begin
            step(0, 16'h0, 5'h0, 1, 5'h13, (q_m[0].pred) ? 2'b10 : 2'b00);
            n_checks++;
            if (flush !== 1'b0) begin n_errors++; $display("FAIL b2b_order pos%0d: flush=%b want 0", i, flush); end
            commit();
        end
    endtask

    task automatic test_empty_resolve();
        step(0, 16'h0005, 5'h0, 1, 5'h15, 2'b00);
        n_checks++;
        if (pc_branch_sel_out !== 1'b1 || flush !== 1'b1) begin
            n_errors++; $display("FAIL er_resolve: sel=%b flush=%b want 1 1", pc_branch_sel_out, flush);
        end
        commit();
        for (int i = 0; i < 16; i++) begin
            step(0, 16'(i), 5'h0, 0, 5'h0, 2'b00);
            n_checks++;
            if (pred_taken !== e_pred) begin n_errors++; $display("FAIL er_bht idx%0d: got %b want %b", i, pred_taken, e_pred); end
            n_checks++;
            if (q_err !== 1'b1) begin n_errors++; $display("FAIL er_qerr: got %b want 1", q_err); end
            commit();
        end
    endtask

    task automatic test_random();
        logic [4:0] ops [8];
        ops[0] = 5'h13; ops[1] = 5'h14; ops[2] = 5'h15; ops[3] = 5'h16;
        ops[4] = 5'h00; ops[5] = 5'h1F; ops[6] = 5'h12; ops[7] = 5'h17;
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), 16'($urandom), ops[$urandom_range(0, 7)],
                 ($urandom_range(0, 2) != 0), ops[$urandom_range(0, 5)], 2'($urandom));
            n_checks++;
            if (pred_taken !== e_pred || q_full !== e_full) begin
                n_errors++; $display("FAIL rnd_fetch c%0d: pred=%b full=%b want %b %b", c, pred_taken, q_full, e_pred, e_full);
            end
            n_checks++;
            if (flush !== e_flush || pc_branch_sel_out !== e_sel) begin
                n_errors++; $display("FAIL rnd_ex c%0d: flush=%b sel=%b want %b %b", c, flush, pc_branch_sel_out, e_flush, e_sel);
            end
            n_checks++;
            if (q_err !== qerr_m || br_cnt !== 16'(br_m) || mispred_cnt !== 16'(mis_m)) begin
                n_errors++; $display("FAIL rnd_stats c%0d: qerr=%b br=%0d mis=%0d want %b %0d %0d",
                                     c, q_err, br_cnt, mispred_cnt, qerr_m, br_m, mis_m);
            end
            n_checks++;
            if (br_cnt4 !== 4'(br4_m) || mispred_cnt4 !== 4'(mis4_m)) begin
                n_errors++; $display("FAIL rnd_stats4 c%0d: br=%0d mis=%0d want %0d %0d", c, br_cnt4, mispred_cnt4, br4_m, mis4_m);
            end
            commit();
        end
    endtask

    task automatic test_sat_cnt();
        step(0, 16'h0, 5'h0, 0, 5'h0, 2'b00);
        n_checks++;
        if (br_m < 17 || br_cnt4 !== 4'd15) begin
            n_errors++; $display("FAIL sat_cnt4: br_cnt=%0d want 15 (branches=%0d)", br_cnt4, br_m);
        end
        commit();
    endtask

    initial begin
        rst_n = 1'b0;
        fet_vld = 0; fet_pc = '0; fet_opcode = '0;
        ex_vld = 0; ex_opcode = '0; ex_flags = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_mispredict();
        test_full();
        test_saturate();
        test_back_to_back();
        test_empty_resolve();
        test_random();
        test_sat_cnt();
        test_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch resolver.
- Adds a 2-bit saturating-counter branch history table (BHT), indexed by PC, that predicts at fetch.
- Holds in-flight predictions in a small FIFO and resolves each one at EX against the ALU flags.
- Raises flush/redirect on mispredict, and keeps saturating branch and mispredict statistics for the debug bus.

Parameters:
- PC_W, 16, program counter width.
- IDX_W, 4, BHT index width; the table has 2^IDX_W entries indexed by pc[IDX_W-1:0].
- INIT_CTR, 2'b01, reset value of every BHT counter (weakly not-taken).
- QDEPTH, 4, in-flight prediction FIFO depth; must be a power of 2 and at least 2.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- fet_vld  in  1  fetch slot valid
- fet_pc  in  PC_W  PC of the fetched instruction
- fet_opcode  in  5  predecoded opcode of the fetched instruction
- pred_taken  out  1  prediction for fet_pc; combinational, equals bht[idx][1]
- q_full  out  1  prediction FIFO full; fetch must stall
- ex_vld  in  1  EX slot valid
- ex_opcode  in  5  opcode at EX
- ex_flags  in  2  ALU flags: [1]=Z (equal), [0]=N (less-than)
- pc_branch_sel_out  out  1  1 = select branch target, 0 = select PC+1; combinational
- flush  out  1  mispredict; kill younger instructions; combinational
- q_err  out  1  sticky; set when a branch resolves while the FIFO is empty
- br_cnt  out  CNT_W  resolved-branch count, saturating
- mispred_cnt  out  CNT_W  mispredict count, saturating

Interface decision: single clock clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Branch opcodes: BEQ=5'b10011, BLT=5'b10100, BGT=5'b10101, BNE=5'b10110. Any other opcode is a non-branch.
- Actual outcome:
  - BEQ taken if Z.
  - BNE taken if !Z.
  - BLT taken if N.
  - BGT taken if !Z && !N.
- Reset (asynchronous, rst_n=0):
  - All BHT entries = INIT_CTR.
  - FIFO empty; q_full=0; q_err=0; br_cnt=0; mispred_cnt=0.
  - Combinational outputs then follow their inputs: pred_taken=INIT_CTR[1]; flush=0 and pc_branch_sel_out=0 unless an EX branch is presented.
- Push: when fet_vld && is_branch(fet_opcode) && !q_full && !flush, push {fet_pc[IDX_W-1:0], pred_taken} at the clock edge.
  - Push while full is dropped. q_full gates fetch upstream, so a dropped push is a protocol violation.
- Resolve: when ex_vld && is_branch(ex_opcode):
  - Pop the FIFO head {idx, pred}.
  - pc_branch_sel_out = actual; flush = (actual != pred). Both are combinational in the same cycle.
  - At the clock edge: update bht[idx] (increment if actual, decrement if not, saturating at 0 and 3); br_cnt++; mispred_cnt++ if flush. Both statistics counters saturate at all-ones.
- Resolve with an empty FIFO:
  - Set q_err; treat pred=0; compute flush and pc_branch_sel_out as above.
  - No BHT update. Statistics still count.
- Non-branch or !ex_vld: pc_branch_sel_out=0, flush=0, no pop.
- Flush:
  - At the same edge as the pop, all remaining FIFO entries are discarded (FIFO becomes empty).
  - A same-cycle push is suppressed.
- Same-cycle push and pop with no flush: both take effect and the occupancy is unchanged. This is legal when the FIFO is full.
- Same-cycle fetch read and BHT write to the same index: the read returns the old value; there is no bypass.
- Pointers are log2(QDEPTH)+1 bits wide; the extra bit separates full from empty. Wrap-around is natural modulo.
- Reset mid-operation: everything returns to reset values immediately; in-flight predictions are lost.

Decomposition:
- Package cpu_br_pkg:
  - Opcode localparams BEQ, BLT, BGT, BNE.
  - typedef bht_ctr_t (logic [1:0]).
  - Functions is_branch(opcode) and br_actual(opcode, flags).
  - Intended to be shared with the decoder.
- Sub-module br_pred_fifo:
  - Parametrised by width and depth.
  - Ports: push, pop, clr, din, dout, full, empty.
  - clr has priority over push.
- The top level holds the BHT array, resolve logic and statistics counters.

Test Plan:
- Reset with rst_n=0 mid-run → q_err=0, br_cnt=0, and pred_taken=0 for every index.
- Push BEQ at pc=0x0005; resolve with flags=2'b10 → pc_branch_sel_out=1, flush=1, bht[5]=2'b10, br_cnt=1, mispred_cnt=1. Fetch pc=0x0015 next → pred_taken=1.
- Push 4 BNE with fet_vld held → q_full=1 after the 4th; 5th push dropped. Resolve 1 with flags=2'b00 (taken, pred=0) → flush=1, FIFO empty, q_full=0.
- Same index, 4 consecutive taken BLT (flags=2'b01), each pushed then resolved → counter 01→10→11→11 (saturates); mispred_cnt increments only on the first.
- FIFO full with push and pop in the same cycle and no mispredict → occupancy stays 4, q_full stays 1, FIFO order preserved.
- ex_vld with BGT and flags=2'b00 on an empty FIFO → q_err=1 (sticky), pc_branch_sel_out=1, flush=1, no BHT change. A run with CNT_W=4 and 17 branches → br_cnt holds at 15.
